// File: rtl/fifo_rd_packer_if.sv
// Stream bundle between the upstream FIFO read port, the packer and the word consumer.
// master = packer side, slave = FIFO/consumer side.
interface fifo_rd_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    logic                      fifo_empty;
    logic                      fifo_rd_en;
    logic [IN_WIDTH-1:0]       fifo_dout;
    logic                      flush;
    logic                      flush_ack;
    logic                      out_valid;
    logic                      out_ready;
    logic [IN_WIDTH*RATIO-1:0] out_data;
    logic [RATIO-1:0]          out_keep;
    logic                      out_last;

    modport master (
        input  fifo_empty, fifo_dout, flush, out_ready,
        output fifo_rd_en, flush_ack, out_valid, out_data, out_keep, out_last
    );

    modport slave (
        output fifo_empty, fifo_dout, flush, out_ready,
        input  fifo_rd_en, flush_ack, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops IN_WIDTH entries from a one-cycle-latency FIFO and packs RATIO of them per output word;
// a flush emits any partial word with a lane-keep mask and out_last set.
module fifo_rd_packer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    fifo_rd_packer_if.master io_bus
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int CNT_WIDTH = $clog2(RATIO + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RATIO - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(RATIO);
    localparam logic [CNT_WIDTH:0]   PEND_FULL = (CNT_WIDTH + 1)'(RATIO);

    typedef enum logic [1:0] {
        ST_PACK  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    state_t                r_state;
    logic [OUT_WIDTH-1:0]  r_acc;
    logic [CNT_WIDTH-1:0]  r_acc_cnt;
    logic                  r_inflight;
    logic [OUT_WIDTH-1:0]  r_out_data;
    logic [RATIO-1:0]      r_out_keep;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_flush_ack;

    logic                  w_slot_free;
    logic [CNT_WIDTH:0]    w_pending;
    logic                  w_room;
    logic                  w_rd_en;
    logic [RATIO-1:0]      w_part_keep;
    logic [OUT_WIDTH-1:0]  w_lane_mask;

    // Read issue: never pop more than the accumulator plus output register can absorb.
    always_comb begin
        w_slot_free = !r_out_valid || io_bus.out_ready;
        w_pending   = {1'b0, r_acc_cnt} + {{CNT_WIDTH{1'b0}}, r_inflight};
        w_room      = (w_pending < PEND_FULL) ||
                      (r_inflight && (r_acc_cnt == CNT_LAST) && w_slot_free);
        w_rd_en     = !i_rst && (r_state == ST_PACK) && !io_bus.flush &&
                      !io_bus.fifo_empty && w_room;
        w_part_keep = {RATIO{1'b0}};
        w_lane_mask = {OUT_WIDTH{1'b0}};
        for (int i = 0; i < RATIO; i++) begin
            w_part_keep[i] = (32'(i) < 32'(r_acc_cnt));
            w_lane_mask[i*IN_WIDTH +: IN_WIDTH] = {IN_WIDTH{w_part_keep[i]}};
        end
    end

    // Accumulator, output register and flush FSM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_PACK;
            r_acc       <= {OUT_WIDTH{1'b0}};
            r_acc_cnt   <= CNT_ZERO;
            r_inflight  <= 1'b0;
            r_out_data  <= {OUT_WIDTH{1'b0}};
            r_out_keep  <= {RATIO{1'b0}};
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_flush_ack <= 1'b0;
        end else begin
            r_inflight  <= w_rd_en;
            r_flush_ack <= 1'b0;
            if (r_out_valid && io_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            // A completing beat bypasses the accumulator straight into a free output slot.
            if (r_inflight) begin
                if ((r_acc_cnt == CNT_LAST) && w_slot_free) begin
                    r_out_data  <= {io_bus.fifo_dout, r_acc[OUT_WIDTH-IN_WIDTH-1:0]};
                    r_out_keep  <= {RATIO{1'b1}};
                    r_out_last  <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_acc_cnt   <= CNT_ZERO;
                end else begin
                    for (int i = 0; i < RATIO; i++) begin
                        if (r_acc_cnt == CNT_WIDTH'(i)) begin
                            r_acc[i*IN_WIDTH +: IN_WIDTH] <= io_bus.fifo_dout;
                        end
                    end
                    r_acc_cnt <= r_acc_cnt + CNT_ONE;
                end
            end else if ((r_state == ST_PACK) && (r_acc_cnt == CNT_FULL) && w_slot_free) begin
                r_out_data  <= r_acc;
                r_out_keep  <= {RATIO{1'b1}};
                r_out_last  <= 1'b0;
                r_out_valid <= 1'b1;
                r_acc_cnt   <= CNT_ZERO;
            end

            case (r_state)
                ST_PACK: begin
                    if (io_bus.flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!r_inflight) begin
                        if (r_acc_cnt == CNT_ZERO) begin
                            r_flush_ack <= 1'b1;
                            r_state     <= ST_PACK;
                        end else begin
                            r_state <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_slot_free) begin
                        r_out_data  <= r_acc & w_lane_mask;
                        r_out_keep  <= w_part_keep;
                        r_out_last  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_acc_cnt   <= CNT_ZERO;
                        r_flush_ack <= 1'b1;
                        r_state     <= ST_PACK;
                    end
                end
                default: begin
                    r_state <= ST_PACK;
                end
            endcase
        end
    end

    assign io_bus.fifo_rd_en = w_rd_en;
    assign io_bus.flush_ack  = r_flush_ack;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.out_data   = r_out_data;
    assign io_bus.out_keep   = r_out_keep;
    assign io_bus.out_last   = r_out_last;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-based FIFO model upstream, word collector downstream,
// expected words computed from the pushed byte stream.
module tb_fifo_rd_packer;
    localparam int IN_WIDTH = 8;
    localparam int RATIO    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_rd_packer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) bus ();

    fifo_rd_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_count = 0;
    bit          rd_on_empty = 1'b0;
    bit          unstable = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = 32'h0;
    logic [7:0]  fq[$];
    logic [7:0]  pushed[$];
    logic [31:0] obs_data[$];
    logic [3:0]  obs_keep[$];
    bit          obs_last[$];
    int          obs_cyc[$];

    // One clock: observe outputs at the negedge, then model the FIFO read after the posedge.
    task automatic tick();
        bit rd_now;
        @(negedge clk);
        rd_now = bus.fifo_rd_en;
        if (rd_now) begin
            rd_count++;
            if (bus.fifo_empty) rd_on_empty = 1'b1;
        end
        if (prev_stall && (!bus.out_valid || (bus.out_data !== prev_data))) unstable = 1'b1;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        if (bus.out_valid && bus.out_ready) begin
            obs_data.push_back(bus.out_data);
            obs_keep.push_back(bus.out_keep);
            obs_last.push_back(bus.out_last);
            obs_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            fq.delete();
            prev_stall = 1'b0;
        end else if (rd_now) begin
            bus.fifo_dout = fq.pop_front();
        end
        bus.fifo_empty = (fq.size() == 0);
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        pushed.push_back(b);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_keep.delete();
        obs_last.delete();
        obs_cyc.delete();
        pushed.delete();
    endtask

    task automatic run_words(input int n, input int budget);
        for (int k = 0; k < budget && obs_data.size() < n; k++) tick();
    endtask

    // Reference packing: word k holds pushed bytes 4k..4k+3, oldest in the low lane.
    function automatic logic [31:0] exp_word(input int k);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < RATIO; i++) w = w | (32'(pushed[k*RATIO+i]) << (8*i));
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout = 8'h00;
        tick();
        tick();
        push(8'h55);
        #1;
        checks++;
        if (bus.fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL reset_rd_en: got %b expected 0", bus.fifo_rd_en);
        end
        checks++;
        if ({bus.out_valid, bus.out_last, bus.flush_ack} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got valid/last/ack=%b expected 000",
                               {bus.out_valid, bus.out_last, bus.flush_ack});
        end
        checks++;
        if ({bus.out_data, bus.out_keep} !== 36'h0) begin
            errors++; $display("FAIL reset_data: got data=%h keep=%h expected 0", bus.out_data, bus.out_keep);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        int start;
        bus.out_ready = 1'b1;
        clear_obs();
        start = cyc;
        for (int b = 1; b <= 8; b++) push(8'(b));
        run_words(2, 40);
        repeat (6) tick();
        checks++;
        if (obs_data.size() != 2) begin
            errors++; $display("FAIL stream_count: got %0d words expected 2", obs_data.size());
        end
        if (obs_data.size() >= 2) begin
            checks++;
            if (obs_data[0] !== 32'h04030201 || obs_data[1] !== 32'h08070605) begin
                errors++; $display("FAIL stream_data: got %h %h expected 04030201 08070605", obs_data[0], obs_data[1]);
            end
            checks++;
            if (obs_keep[0] !== 4'hF || obs_keep[1] !== 4'hF || obs_last[0] || obs_last[1]) begin
                errors++; $display("FAIL stream_keep_last: got keep %h %h last %0b %0b expected F F 0 0",
                                   obs_keep[0], obs_keep[1], obs_last[0], obs_last[1]);
            end
            checks++;
            if (obs_cyc[0] - start != 5) begin
                errors++; $display("FAIL stream_latency: got %0d cycles expected 5", obs_cyc[0] - start);
            end
            checks++;
            if (obs_cyc[1] - obs_cyc[0] != 4) begin
                errors++; $display("FAIL stream_spacing: got %0d cycles expected 4", obs_cyc[1] - obs_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        clear_obs();
        rd_count = 0;
        unstable = 1'b0;
        for (int b = 1; b <= 12; b++) push(8'(b));
        repeat (10) tick();
        checks++;
        if (rd_count != 8) begin
            errors++; $display("FAIL bp_reads: got %0d reads expected 8", rd_count);
        end
        checks++;
        if (fq.size() != 4 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: got fifo left %0d valid %b expected 4 1", fq.size(), bus.out_valid);
        end
        bus.out_ready = 1'b1;
        run_words(3, 40);
        repeat (8) tick();
        checks++;
        if (obs_data.size() != 3) begin
            errors++; $display("FAIL bp_count: got %0d words expected 3", obs_data.size());
        end
        for (int k = 0; k < obs_data.size() && k < 3; k++) begin
            checks++;
            if (obs_data[k] !== exp_word(k) || obs_keep[k] !== 4'hF || obs_last[k]) begin
                errors++; $display("FAIL bp_word%0d: got %h keep %h last %0b expected %h F 0",
                                   k, obs_data[k], obs_keep[k], obs_last[k], exp_word(k));
            end
        end
        checks++;
        if (unstable) begin
            errors++; $display("FAIL bp_stable: got output change under stall expected none");
        end
    endtask

    task automatic test_partial_flush();
        int ack_k;
        logic [31:0] d;
        logic [3:0] kp;
        bit v, l;
        bus.out_ready = 1'b1;
        clear_obs();
        push(8'hAA);
        push(8'hBB);
        repeat (6) tick();
        bus.flush = 1'b1;
        ack_k = 0;
        d = 32'h0; kp = 4'h0; v = 1'b0; l = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.flush = 1'b0;
            if (bus.flush_ack && ack_k == 0) begin
                ack_k = k; v = bus.out_valid; d = bus.out_data; kp = bus.out_keep; l = bus.out_last;
            end
        end
        checks++;
        if (ack_k != 3) begin
            errors++; $display("FAIL pflush_ack_time: got %0d expected 3", ack_k);
        end
        checks++;
        if (!v || d !== 32'h0000BBAA || kp !== 4'h3 || !l) begin
            errors++; $display("FAIL pflush_word: got valid %0b data %h keep %h last %0b expected 1 0000bbaa 3 1",
                               v, d, kp, l);
        end
    endtask

    task automatic test_flush_race();
        int ack_k;
        int rd_before;
        bus.out_ready = 1'b1;
        clear_obs();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (3) tick();
        push(8'h44);
        push(8'h55);
        bus.flush = 1'b1;
        rd_count = 0;
        ack_k = 0;
        rd_before = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.flush = 1'b0;
            if (bus.flush_ack && ack_k == 0) begin
                ack_k = k; rd_before = rd_count;
            end
        end
        checks++;
        if (ack_k != 3 || rd_before != 0) begin
            errors++; $display("FAIL race_ack: got ack at %0d with %0d reads expected 3 with 0", ack_k, rd_before);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        repeat (6) tick();
        checks++;
        if (obs_data.size() != 2) begin
            errors++; $display("FAIL race_count: got %0d words expected 2", obs_data.size());
        end
        if (obs_data.size() >= 2) begin
            checks++;
            if (obs_data[0] !== 32'h00332211 || obs_keep[0] !== 4'h7 || !obs_last[0]) begin
                errors++; $display("FAIL race_word: got %h keep %h last %0b expected 00332211 7 1",
                                   obs_data[0], obs_keep[0], obs_last[0]);
            end
            checks++;
            if (obs_data[1] !== 32'h00005544 || obs_keep[1] !== 4'h3 || !obs_last[1]) begin
                errors++; $display("FAIL race_tail: got %h keep %h last %0b expected 00005544 3 1",
                                   obs_data[1], obs_keep[1], obs_last[1]);
            end
        end
    endtask

    task automatic test_empty_flush();
        int ack_k;
        int ack_n;
        bit valid_seen;
        bus.out_ready = 1'b1;
        clear_obs();
        repeat (3) tick();
        bus.flush = 1'b1;
        ack_k = 0; ack_n = 0; valid_seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.flush = 1'b0;
            if (bus.flush_ack) begin
                ack_n++;
                if (ack_k == 0) ack_k = k;
            end
            if (bus.out_valid) valid_seen = 1'b1;
        end
        checks++;
        if (ack_k != 2 || ack_n != 1) begin
            errors++; $display("FAIL eflush_ack: got first at %0d count %0d expected 2 1", ack_k, ack_n);
        end
        checks++;
        if (valid_seen) begin
            errors++; $display("FAIL eflush_valid: got out_valid=1 expected never");
        end
    endtask

    task automatic test_mid_word_reset();
        bus.out_ready = 1'b1;
        clear_obs();
        push(8'hAA);
        push(8'hBB);
        push(8'hCC);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.out_last, bus.flush_ack, bus.fifo_rd_en} !== 4'b0000 ||
            {bus.out_data, bus.out_keep} !== 36'h0) begin
            errors++; $display("FAIL mreset_outputs: got valid/last/ack/rd=%b data %h keep %h expected all 0",
                               {bus.out_valid, bus.out_last, bus.flush_ack, bus.fifo_rd_en},
                               bus.out_data, bus.out_keep);
        end
        rst = 1'b0;
        clear_obs();
        for (int b = 1; b <= 4; b++) push(8'(b));
        run_words(1, 30);
        repeat (8) tick();
        checks++;
        if (obs_data.size() != 1) begin
            errors++; $display("FAIL mreset_count: got %0d words expected 1", obs_data.size());
        end else begin
            checks++;
            if (obs_data[0] !== 32'h04030201 || obs_keep[0] !== 4'hF || obs_last[0]) begin
                errors++; $display("FAIL mreset_word: got %h keep %h last %0b expected 04030201 F 0",
                                   obs_data[0], obs_keep[0], obs_last[0]);
            end
        end
    endtask

    task automatic test_random();
        int sent;
        int bad;
        clear_obs();
        unstable = 1'b0;
        sent = 0;
        bad = 0;
        for (int k = 0; k < 3000 && obs_data.size() < 16; k++) begin
            bus.out_ready = ($urandom_range(0, 9) < 6);
            if (sent < 64 && $urandom_range(0, 2) != 0) begin
                push(8'($urandom_range(0, 255)));
                sent++;
            end
            tick();
        end
        bus.out_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (obs_data.size() != 16) begin
            errors++; $display("FAIL rand_count: got %0d words expected 16", obs_data.size());
        end
        for (int k = 0; k < obs_data.size() && k < 16; k++) begin
            checks++;
            if (obs_data[k] !== exp_word(k) || obs_keep[k] !== 4'hF || obs_last[k]) begin
                errors++;
                if (bad < 4) $display("FAIL rand_word%0d: got %h keep %h last %0b expected %h F 0",
                                      k, obs_data[k], obs_keep[k], obs_last[k], exp_word(k));
                bad++;
            end
        end
        checks++;
        if (unstable || rd_on_empty) begin
            errors++; $display("FAIL rand_protocol: got unstable=%0b rd_on_empty=%0b expected 0 0",
                               unstable, rd_on_empty);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_partial_flush();
        test_flush_race();
        test_empty_flush();
        test_mid_word_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
